// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (req0) and load (req1) writeback.
// One-cycle registered latency to we3/a3/wd3; stall or reset withholds both readys, and requesters hold until ready.
module regfile_wr_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_hit
);

  logic              last_grant;
  logic              grant0;
  logic              grant1;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

  // Under contention the requester that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && !stall) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign win_addr   = grant1 ? req1_addr : req0_addr;
  assign win_data   = grant1 ? req1_data : req0_data;

  // Writes to x0 are consumed but never enabled onto the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
      last_grant <= 1'b1;
    end else if (grant0 || grant1) begin
      we3        <= (win_addr != '0);
      a3         <= win_addr;
      wd3        <= win_data;
      last_grant <= grant1;
    end else begin
      we3        <= 1'b0;
    end
  end

  assign chk_hit = (chk_addr != '0) &&
                   ((req0_valid && (req0_addr == chk_addr)) ||
                    (req1_valid && (req1_addr == chk_addr)) ||
                    (we3 && (a3 == chk_addr)));

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: readys/chk_hit checked per cycle, port writes via a scoreboard queue.
module tb_regfile_wr_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_addr, req1_addr, a3, chk_addr;
  logic [31:0] req0_data, req1_data, wd3;
  logic        we3, chk_hit;

  int checks   = 0;
  int failures = 0;

  wr_t         sb[$];
  logic [4:0]  m_a;
  logic [31:0] m_d;

  always #5 clk = ~clk;

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .we3(we3), .a3(a3), .wd3(wd3), .chk_addr(chk_addr), .chk_hit(chk_hit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: checks the port write from the last edge, drives one cycle, checks comb outputs.
  task automatic cyc(input string tag, input logic r, input logic s,
                     input logic v0, input logic [4:0] ad0, input logic [31:0] d0,
                     input logic v1, input logic [4:0] ad1, input logic [31:0] d1,
                     input logic [4:0] ck, input logic e_r0, input logic e_r1, input logic e_hit);
    wr_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ":we3"}, {31'd0, we3}, {31'd0, e.we});
      check({tag, ":a3"},  {27'd0, a3},  {27'd0, e.a});
      check({tag, ":wd3"}, wd3, e.d);
    end
    rst = r; stall = s;
    req0_valid = v0; req0_addr = ad0; req0_data = d0;
    req1_valid = v1; req1_addr = ad1; req1_data = d1;
    chk_addr = ck;
    #1;
    check({tag, ":req0_ready"}, {31'd0, req0_ready}, {31'd0, e_r0});
    check({tag, ":req1_ready"}, {31'd0, req1_ready}, {31'd0, e_r1});
    check({tag, ":chk_hit"},    {31'd0, chk_hit},    {31'd0, e_hit});
    if (r) begin
      m_a = '0; m_d = '0;
      e = '{we: 1'b0, a: 5'd0, d: 32'd0};
    end else if (e_r0) begin
      m_a = ad0; m_d = d0;
      e = '{we: (ad0 != 5'd0), a: ad0, d: d0};
    end else if (e_r1) begin
      m_a = ad1; m_d = d1;
      e = '{we: (ad1 != 5'd0), a: ad1, d: d1};
    end else begin
      e = '{we: 1'b0, a: m_a, d: m_d};
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    m_a = '0; m_d = '0;
    @(negedge clk);
    // Reset with both requesters valid: no grants.
    cyc("rst0", 1, 0, 1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd0, 0, 0, 0);
    cyc("rst1", 1, 0, 1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd0, 0, 0, 0);
    // Release: req0 wins first contention, req1 follows.
    cyc("rel0", 0, 0, 1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd5, 1, 0, 1);
    cyc("rel1", 0, 0, 0, 5'd0, 32'h0,  1, 5'd6, 32'h66, 5'd5, 0, 1, 1);
    // Single requester 1.
    cyc("one0", 0, 0, 0, 5'd0, 32'h0, 1, 5'd10, 32'hDEADBEEF, 5'd10, 0, 1, 1);
    cyc("one1", 0, 0, 0, 5'd0, 32'h0, 0, 5'd0,  32'h0,        5'd10, 0, 0, 1);
    cyc("one2", 0, 0, 0, 5'd0, 32'h0, 0, 5'd0,  32'h0,        5'd10, 0, 0, 0);
    // Continuous contention (last grant was 1): 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) begin
      cyc("cont", 0, 0, 1, 5'd3, 32'h3000 + i, 1, 5'd4, 32'h4000 + i, 5'd4,
          (i % 2) == 0, (i % 2) == 1, 1);
    end
    // x0 write accepted but never enabled; chk on x0 never hits.
    cyc("x0a", 0, 0, 1, 5'd0, 32'h1234, 0, 5'd0, 32'h0, 5'd0, 1, 0, 0);
    cyc("x0b", 0, 0, 0, 5'd0, 32'h0,    0, 5'd0, 32'h0, 5'd0, 0, 0, 0);
    // Stall holds req1; hazard visible while pending and while on the port.
    cyc("stl0", 0, 1, 0, 5'd0, 32'h0, 1, 5'd7, 32'h77, 5'd7, 0, 0, 1);
    cyc("stl1", 0, 1, 0, 5'd0, 32'h0, 1, 5'd7, 32'h77, 5'd7, 0, 0, 1);
    cyc("stl2", 0, 0, 0, 5'd0, 32'h0, 1, 5'd7, 32'h77, 5'd7, 0, 1, 1);
    cyc("stl3", 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  5'd7, 0, 0, 1);
    cyc("stl4", 0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,  5'd7, 0, 0, 0);
    // Reset right after a transfer to x9 drops it and restores last_grant=1.
    cyc("mrs0", 0, 0, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 5'd9, 1, 0, 1);
    cyc("mrs1", 1, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0, 5'd9, 0, 0, 1);
    cyc("mrs2", 0, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 5'd9, 1, 0, 0);
    cyc("mrs3", 0, 0, 0, 5'd0, 32'h0,  1, 5'd2, 32'h22, 5'd1, 0, 1, 1);
    // Same address from both: grant order decides landing order.
    cyc("same0", 0, 0, 1, 5'd8, 32'hA0, 1, 5'd8, 32'hB0, 5'd8, 1, 0, 1);
    cyc("same1", 0, 0, 0, 5'd0, 32'h0,  1, 5'd8, 32'hB0, 5'd8, 0, 1, 1);
    cyc("drn0",  0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd8, 0, 0, 1);
    cyc("drn1",  0, 0, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  5'd8, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
